cr_osf_lat_mon: RTL and testbench
=================================

# cr_osf_lat_mon

Passive latency monitor on the OSF output AXI4-Stream. It parses the STAT TLV of each completed command, extracts the 24-bit latency field and frame-error flag from stats word 2 (the word the OSF latency inserter overwrites), and keeps running latency statistics plus a threshold alarm. It sits on the same `axi4s_dp_bus_t` stream as the inserter, downstream of it. It never modifies or stalls the stream.

## Interface
Parameters:
- `LAT_THRESH`, default 24'h00_1000: latency above this value raises `lat_alarm`.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `axi4s_in`  in  `axi4s_dp_bus_t`  observed stream.
- `axi4s_mstr_rd`  in  1  beat accepted this cycle.
- `stat_clr`  in  1  synchronous clear of all statistics.
- `lat_vld`  out  1  one-cycle pulse: a new sample has been folded in.
- `lat_last`  out  24  most recent latency sample.
- `lat_min`  out  24  minimum sample since clear.
- `lat_max`  out  24  maximum sample since clear.
- `lat_sum`  out  48  saturating sum of samples.
- `lat_cnt`  out  32  saturating sample count.
- `frm_err_cnt`  out  16  saturating count of samples with `frame_error` set.
- `malformed_cnt`  out  16  saturating count of truncated STAT TLVs.
- `lat_alarm`  out  1  sticky; set when a sample exceeds `LAT_THRESH`.

## Operation
- Beat decode: `sot` = (`tuser` == 8'h1). Word 0 is `tlv_word_0_t`. Word 2 is `tlv_stats_word2_t`; latency = bits [23:0].
- Only beats with `axi4s_mstr_rd`=1 advance the FSM. `tvalid` alone has no effect.
- FSM states:
  - `IDLE`: accepted beat with `sot` and `tlv_type`==STAT -> `W1`.
  - `W1`: accepted beat -> `W2`. If that beat has `tlast`=1, increment `malformed_cnt` and go to `IDLE`.
  - `W2`: accepted beat -> capture the sample, then `IDLE`. If this beat has `sot`=1, count it as malformed, take no sample, and re-evaluate the beat as if in `IDLE`.
- In `W1` and `W2`, a non-accepted cycle holds state. There is no timeout.
- Capture of latency L, applied on the next clock edge:
  - `lat_last`=L.
  - `lat_min`=min(`lat_min`,L); `lat_max`=max(`lat_max`,L).
  - `lat_sum`+=L, saturating at 48'hFFFF_FFFF_FFFF.
  - `lat_cnt`+=1, saturating at all-ones.
  - If `frame_error` is set, `frm_err_cnt`+=1, saturating.
  - If L>`LAT_THRESH` (unsigned), set `lat_alarm`.
- `stat_clr` resets `lat_min` to 24'hFFFFFF and everything else to 0, including `lat_alarm`. It does not affect the FSM.
- `stat_clr` in the same cycle as a capture: the clear is applied first, then the sample. Result: `lat_cnt`=1, `lat_min`=`lat_max`=`lat_sum`=L.

## Timing
- All outputs are registered.
- Statistics update and `lat_vld` pulse 1 cycle after the clock edge on which word 2 is accepted.
- Back-to-back STAT TLVs with no gap are supported. Minimum sample spacing is 3 accepted beats.
- Reset values:
  - FSM `IDLE`.
  - `lat_min`=24'hFFFFFF.
  - All other outputs 0.
- Reset mid-TLV discards the partial TLV and does not count it as malformed.
- The `axi4s_in` to FSM path is combinational decode only: one compare level on `tuser` and `tlv_type`.

## Test plan
- Single STAT TLV, word 2 latency 24'h000123, `frame_error`=0, `mstr_rd` held high -> one `lat_vld` pulse; `lat_last`=`lat_min`=`lat_max`=24'h123, `lat_sum`=48'h123, `lat_cnt`=1.
- Three TLVs with latencies 10, 5, 20, with `mstr_rd` deasserted randomly mid-TLV -> `lat_min`=5, `lat_max`=20, `lat_sum`=35, `lat_cnt`=3. Stalls are not counted as beats.
- STAT TLV with `tlast` on word 1; also a new STAT `sot` arriving while in `W2` -> `malformed_cnt`=2; the second TLV is still captured correctly.
- Latency 24'h001001 with `frame_error`=1 -> `lat_alarm`=1 and `frm_err_cnt`=1. A following sample of 24'h000010 leaves `lat_alarm`=1.
- `stat_clr` in the same cycle as the word-2 accept with L=7 -> `lat_cnt`=1, `lat_min`=`lat_max`=`lat_sum`=7. An RQE TLV and a non-STAT TLV on the stream produce no sample.
- `rst_n` asserted during `W2`, then a full STAT TLV with L=9 -> all outputs return to reset values, then exactly one sample of 9 is recorded and `malformed_cnt`=0.

Source files
------------

// File: rtl/cr_osf_lat_mon.sv
// OSF output latency monitor: passively decodes the STAT TLV on the output stream and
// keeps running latency statistics (min/max/sum/count), error counters and a sticky alarm.
package cr_osf_pkg;
    localparam logic [7:0] TLV_DATA = 8'h01;
    localparam logic [7:0] TLV_STAT = 8'h02;
    localparam logic [7:0] TLV_RQE  = 8'h03;

    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic        tlast;
        logic [7:0]  tuser;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic [55:0] rsvd;
        logic [7:0]  tlv_type;
    } tlv_word_0_t;

    typedef struct packed {
        logic [38:0] rsvd;
        logic        frame_error;
        logic [23:0] latency;
    } tlv_stats_word2_t;
endpackage

module cr_osf_lat_mon
    import cr_osf_pkg::*;
#(
    parameter logic [23:0] LAT_THRESH = 24'h00_1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  axi4s_dp_bus_t axi4s_in,
    input  logic          axi4s_mstr_rd,
    input  logic          stat_clr,
    output logic          lat_vld,
    output logic [23:0]   lat_last,
    output logic [23:0]   lat_min,
    output logic [23:0]   lat_max,
    output logic [47:0]   lat_sum,
    output logic [31:0]   lat_cnt,
    output logic [15:0]   frm_err_cnt,
    output logic [15:0]   malformed_cnt,
    output logic          lat_alarm
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_W1   = 2'd1;
    localparam logic [1:0] ST_W2   = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [23:0] b);
        logic [48:0] s;
        s = {1'b0, a} + {25'd0, b};
        return s[48] ? 48'hFFFF_FFFF_FFFF : s[47:0];
    endfunction

    tlv_word_0_t      w0;
    tlv_stats_word2_t w2;
    logic             sot, stat_sot, acc;
    logic             unused_bits;

    assign w0          = tlv_word_0_t'(axi4s_in.tdata);
    assign w2          = tlv_stats_word2_t'(axi4s_in.tdata);
    assign acc         = axi4s_mstr_rd;
    assign sot         = (axi4s_in.tuser == 8'h01);
    assign stat_sot    = sot && (w0.tlv_type == TLV_STAT);
    assign unused_bits = ^{axi4s_in.tvalid, w0.rsvd, w2.rsvd};

    logic [1:0]  state_q, state_d;
    logic        cap, malf;
    logic        vld_q, vld_d, alarm_q, alarm_d;
    logic [23:0] last_q, last_d, min_q, min_d, max_q, max_d;
    logic [47:0] sum_q, sum_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] fe_q, fe_d, malf_q, malf_d;

    // A sot seen in W2 means the previous TLV was cut short; the beat itself may open a new one.
    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        malf    = 1'b0;
        case (state_q)
            ST_IDLE: if (acc && stat_sot) state_d = ST_W1;
            ST_W1: begin
                if (acc) begin
                    if (axi4s_in.tlast) begin
                        malf    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_W2;
                    end
                end
            end
            ST_W2: begin
                if (acc) begin
                    if (sot) begin
                        malf    = 1'b1;
                        state_d = stat_sot ? ST_W1 : ST_IDLE;
                    end else begin
                        cap     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear is folded in ahead of the sample so a coincident capture lands on fresh statistics.
    always_comb begin
        last_d  = stat_clr ? 24'd0        : last_q;
        min_d   = stat_clr ? 24'hFF_FFFF  : min_q;
        max_d   = stat_clr ? 24'd0        : max_q;
        sum_d   = stat_clr ? 48'd0        : sum_q;
        cnt_d   = stat_clr ? 32'd0        : cnt_q;
        fe_d    = stat_clr ? 16'd0        : fe_q;
        malf_d  = stat_clr ? 16'd0        : malf_q;
        alarm_d = stat_clr ? 1'b0         : alarm_q;
        vld_d   = cap;
        if (malf) malf_d = sat_inc16(malf_d);
        if (cap) begin
            last_d = w2.latency;
            if (w2.latency < min_d) min_d = w2.latency;
            if (w2.latency > max_d) max_d = w2.latency;
            sum_d = sat_add48(sum_d, w2.latency);
            cnt_d = sat_inc32(cnt_d);
            if (w2.frame_error) fe_d = sat_inc16(fe_d);
            if (w2.latency > LAT_THRESH) alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            last_q  <= 24'd0;
            min_q   <= 24'hFF_FFFF;
            max_q   <= 24'd0;
            sum_q   <= 48'd0;
            cnt_q   <= 32'd0;
            fe_q    <= 16'd0;
            malf_q  <= 16'd0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            min_q   <= min_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            fe_q    <= fe_d;
            malf_q  <= malf_d;
            alarm_q <= alarm_d;
        end
    end

    assign lat_vld       = vld_q;
    assign lat_last      = last_q;
    assign lat_min       = min_q;
    assign lat_max       = max_q;
    assign lat_sum       = sum_q;
    assign lat_cnt       = cnt_q;
    assign frm_err_cnt   = fe_q;
    assign malformed_cnt = malf_q;
    assign lat_alarm     = alarm_q;
endmodule

// File: tb/tb_cr_osf_lat_mon.sv
// Scoreboard bench for cr_osf_lat_mon: expected statistics snapshots are queued when word 2
// is driven and compared when lat_vld pulses.
module tb_cr_osf_lat_mon;
    import cr_osf_pkg::*;

    localparam logic [23:0] THRESH = 24'h00_1000;

    typedef struct packed {
        logic [23:0] last, min, max;
        logic [47:0] sum;
        logic [31:0] cnt;
        logic [15:0] fe;
        logic        alarm;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    axi4s_dp_bus_t axi4s_in;
    logic          axi4s_mstr_rd, stat_clr;
    logic          lat_vld, lat_alarm;
    logic [23:0]   lat_last, lat_min, lat_max;
    logic [47:0]   lat_sum;
    logic [31:0]   lat_cnt;
    logic [15:0]   frm_err_cnt, malformed_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t m;
    logic [15:0] m_malf;

    always #5 clk = ~clk;

    cr_osf_lat_mon #(.LAT_THRESH(THRESH)) dut (
        .clk(clk), .rst_n(rst_n), .axi4s_in(axi4s_in), .axi4s_mstr_rd(axi4s_mstr_rd),
        .stat_clr(stat_clr), .lat_vld(lat_vld), .lat_last(lat_last), .lat_min(lat_min),
        .lat_max(lat_max), .lat_sum(lat_sum), .lat_cnt(lat_cnt), .frm_err_cnt(frm_err_cnt),
        .malformed_cnt(malformed_cnt), .lat_alarm(lat_alarm)
    );

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        m.last = 24'd0; m.min = 24'hFF_FFFF; m.max = 24'd0; m.sum = 48'd0;
        m.cnt = 32'd0; m.fe = 16'd0; m.alarm = 1'b0;
        m_malf = 16'd0;
    endtask

    task automatic m_sample(input logic [23:0] l, input logic fe);
        logic [48:0] s;
        m.last = l;
        if (l < m.min) m.min = l;
        if (l > m.max) m.max = l;
        s = {1'b0, m.sum} + {25'd0, l};
        m.sum = s[48] ? 48'hFFFF_FFFF_FFFF : s[47:0];
        if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 32'd1;
        if (fe && m.fe != 16'hFFFF) m.fe = m.fe + 16'd1;
        if (l > THRESH) m.alarm = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && lat_vld) begin
            if (sb_q.size() == 0) begin
                chk_val("vld_unexpected", lat_vld, 1'b0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk_val("lat_last", lat_last, e.last);
                chk_val("lat_min", lat_min, e.min);
                chk_val("lat_max", lat_max, e.max);
                chk_val("lat_sum", lat_sum, e.sum);
                chk_val("lat_cnt", lat_cnt, e.cnt);
                chk_val("frm_err_cnt", frm_err_cnt, e.fe);
                chk_val("lat_alarm", lat_alarm, e.alarm);
            end
        end
    end

    task automatic beat(input logic [7:0] tu, input logic [63:0] td, input logic tl,
                        input bit stalls, input logic clr);
        int n;
        n = stalls ? int'($urandom_range(0, 3)) : 0;
        axi4s_in.tvalid = 1'b1;
        axi4s_in.tuser  = tu;
        axi4s_in.tdata  = td;
        axi4s_in.tlast  = tl;
        for (int i = 0; i < n; i++) begin
            axi4s_mstr_rd = 1'b0;
            stat_clr      = 1'b0;
            @(posedge clk); #1;
        end
        axi4s_mstr_rd = 1'b1;
        stat_clr      = clr;
        @(posedge clk); #1;
        axi4s_mstr_rd   = 1'b0;
        stat_clr        = 1'b0;
        axi4s_in.tvalid = 1'b0;
    endtask

    function automatic logic [63:0] mk_w0(input logic [7:0] ty);
        tlv_word_0_t w;
        w.rsvd     = {24'd0, $urandom()};
        w.tlv_type = ty;
        return 64'(w);
    endfunction

    function automatic logic [63:0] mk_w2(input logic [23:0] l, input logic fe);
        tlv_stats_word2_t w;
        w.rsvd        = {7'd0, $urandom()};
        w.frame_error = fe;
        w.latency     = l;
        return 64'(w);
    endfunction

    task automatic stat_tlv(input logic [23:0] l, input logic fe, input bit stalls, input logic clr);
        beat(8'h01, mk_w0(TLV_STAT), 1'b0, stalls, 1'b0);
        beat(8'h00, {$urandom(), $urandom()}, 1'b0, stalls, 1'b0);
        if (clr) m_clear();
        m_sample(l, fe);
        sb_q.push_back(m);
        beat(8'h00, mk_w2(l, fe), 1'b1, stalls, clr);
    endtask

    task automatic other_tlv(input logic [7:0] ty);
        beat(8'h01, mk_w0(ty), 1'b0, 1'b0, 1'b0);
        beat(8'h00, mk_w2(24'h00_FFFF, 1'b1), 1'b0, 1'b0, 1'b0);
        beat(8'h00, mk_w2(24'h00_FFFF, 1'b1), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        m_clear();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_val({tag, "_vld"}, lat_vld, 1'b0);
        chk_val({tag, "_last"}, lat_last, 24'd0);
        chk_val({tag, "_min"}, lat_min, 24'hFF_FFFF);
        chk_val({tag, "_max"}, lat_max, 24'd0);
        chk_val({tag, "_sum"}, lat_sum, 48'd0);
        chk_val({tag, "_cnt"}, lat_cnt, 32'd0);
        chk_val({tag, "_fe"}, frm_err_cnt, 16'd0);
        chk_val({tag, "_malf"}, malformed_cnt, 16'd0);
        chk_val({tag, "_alarm"}, lat_alarm, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        axi4s_in = '0;
        axi4s_mstr_rd = 1'b0;
        stat_clr = 1'b0;
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        stat_tlv(24'h00_0123, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk_val("single_cnt", lat_cnt, 32'd1);

        do_clr();
        chk_val("clr_min", lat_min, 24'hFF_FFFF);
        chk_val("clr_cnt", lat_cnt, 32'd0);
        stat_tlv(24'd10, 1'b0, 1'b1, 1'b0);
        stat_tlv(24'd5,  1'b0, 1'b1, 1'b0);
        stat_tlv(24'd20, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk_val("three_min", lat_min, 24'd5);
        chk_val("three_max", lat_max, 24'd20);
        chk_val("three_sum", lat_sum, 48'd35);

        do_clr();
        beat(8'h01, mk_w0(TLV_STAT), 1'b0, 1'b0, 1'b0);
        beat(8'h00, 64'h1111, 1'b1, 1'b0, 1'b0);
        m_malf = m_malf + 16'd1;
        chk_val("malf_w1_tlast", malformed_cnt, m_malf);
        beat(8'h01, mk_w0(TLV_STAT), 1'b0, 1'b0, 1'b0);
        beat(8'h00, 64'h2222, 1'b0, 1'b0, 1'b0);
        m_malf = m_malf + 16'd1;
        stat_tlv(24'h00_0040, 1'b0, 1'b0, 1'b0);
        chk_val("malf_w2_sot", malformed_cnt, m_malf);
        chk_val("malf_total", malformed_cnt, 16'd2);

        stat_tlv(24'h00_1001, 1'b1, 1'b0, 1'b0);
        stat_tlv(24'h00_0010, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk_val("alarm_sticky", lat_alarm, 1'b1);
        chk_val("fe_cnt", frm_err_cnt, 16'd1);

        stat_tlv(24'd7, 1'b0, 1'b0, 1'b1);
        other_tlv(TLV_RQE);
        other_tlv(TLV_DATA);
        repeat (2) @(posedge clk); #1;
        chk_val("clrcap_cnt", lat_cnt, 32'd1);
        chk_val("clrcap_sum", lat_sum, 48'd7);
        chk_val("clrcap_min", lat_min, 24'd7);
        chk_val("clrcap_malf", malformed_cnt, m_malf);

        beat(8'h01, mk_w0(TLV_STAT), 1'b0, 1'b0, 1'b0);
        beat(8'h00, 64'h3333, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        m_clear();
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stat_tlv(24'd9, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk); #1;
        chk_val("postrst_cnt", lat_cnt, 32'd1);
        chk_val("postrst_last", lat_last, 24'd9);
        chk_val("postrst_malf", malformed_cnt, 16'd0);
        chk_val("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
